// File: rtl/storage_pkg.sv
// Shared constants, edge selection type and count helpers for the multi-edge
// storage capture block and its shift chains.
package storage_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_DEPTH = 2;
  localparam int DEF_CNT_W = 8;

  typedef enum logic {
    EDGE_RISE = 1'b0,
    EDGE_FALL = 1'b1
  } edge_sel_e;

  function automatic int unsigned max_count(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  localparam int unsigned DEF_CNT_MAX = max_count(DEF_CNT_W);

endpackage

// File: rtl/multi_edge_capture_if.sv
// Data/enable/clear inputs and the three capture outputs plus mismatch status
// of the multi-edge capture block.
interface multi_edge_capture_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] D;
  logic             En;
  logic             Clr;
  logic [WIDTH-1:0] Qa;
  logic [WIDTH-1:0] Qb;
  logic [WIDTH-1:0] Qc;
  logic             Diff;
  logic [CNT_W-1:0] Diff_cnt;

  modport master (
    output D, En, Clr,
    input  Qa, Qb, Qc, Diff, Diff_cnt
  );

  modport slave (
    input  D, En, Clr,
    output Qa, Qb, Qc, Diff, Diff_cnt
  );
endinterface

// File: rtl/edge_shift_chain.sv
// DEPTH-stage enabled shift register clocked on the rising or falling edge of
// clk, selected by the EDGE parameter; q is the last stage.
module edge_shift_chain
  import storage_pkg::*;
#(
  parameter int        WIDTH = DEF_WIDTH,
  parameter int        DEPTH = DEF_DEPTH,
  parameter edge_sel_e EDGE  = EDGE_RISE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_p [DEPTH];

  generate
    if (EDGE == EDGE_RISE) begin : g_rise
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) stage_p[i] <= '0;
        end else if (en) begin
          stage_p[0] <= d;
          for (int i = 1; i < DEPTH; i++) stage_p[i] <= stage_p[i-1];
        end
      end
    end else begin : g_fall
      always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) stage_p[i] <= '0;
        end else if (en) begin
          stage_p[0] <= d;
          for (int i = 1; i < DEPTH; i++) stage_p[i] <= stage_p[i-1];
        end
      end
    end
  endgenerate

  assign q = stage_p[DEPTH-1];

endmodule

// File: rtl/multi_edge_capture.sv
// Captures D through a gated latch, a rising-edge chain and a falling-edge
// chain, and counts (saturating) rising edges where the two chains disagree.
module multi_edge_capture
  import storage_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                 Clk,
  input  logic                 Resetn,
  multi_edge_capture_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(max_count(CNT_W));

  logic [WIDTH-1:0] qa;
  logic [WIDTH-1:0] qb;
  logic [WIDTH-1:0] qc;
  logic             diff_p1;
  logic [CNT_W-1:0] cnt_p1;
  logic             mismatch;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  // Gated latch: transparent while Clk and En are both high, cleared by reset
  always_latch begin
    if (!Resetn) begin
      qa = '0;
    end else if (Clk && bus.En) begin
      qa = bus.D;
    end
  end

  edge_shift_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .EDGE(EDGE_RISE)) u_rise (
    .clk   (Clk),
    .rst_n (Resetn),
    .en    (bus.En),
    .d     (bus.D),
    .q     (qb)
  );

  edge_shift_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .EDGE(EDGE_FALL)) u_fall (
    .clk   (Clk),
    .rst_n (Resetn),
    .en    (bus.En),
    .d     (bus.D),
    .q     (qc)
  );

  assign mismatch = (qb != qc);

  // Mismatch stage: not gated by En; Clr wins over a simultaneous mismatch
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      diff_p1 <= 1'b0;
      cnt_p1  <= '0;
    end else if (bus.Clr) begin
      diff_p1 <= 1'b0;
      cnt_p1  <= '0;
    end else begin
      diff_p1 <= mismatch;
      if (mismatch) cnt_p1 <= sat_inc(cnt_p1);
    end
  end

  assign bus.Qa       = qa;
  assign bus.Qb       = qb;
  assign bus.Qc       = qc;
  assign bus.Diff     = diff_p1;
  assign bus.Diff_cnt = cnt_p1;

endmodule
